// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and defaults for the data-memory arbiter.
//                Controller state encoding, default bus widths, wait-state
//                counter width and the requester-index type.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   // Wait-state counter width; covers WAIT_STATES = 0..15.
   localparam int WAIT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Requester index: 0 = core load/store path, 1 = test/DMA loader.
   typedef logic port_idx_t;
   localparam port_idx_t PORT0 = 1'b0;
   localparam port_idx_t PORT1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-input round-robin grant. A single pointer bit names the
//                favoured requester; it is consulted only when both request.
//                Pulsing update moves the pointer to the port that was not
//                just served.
//  Ports       : clk, rst_n    clock / synchronous active-low reset
//                req[1:0]      request vector (bit n = port n)
//                update        strobe: a transaction of 'served' finished
//                served        index of the port that just finished
//                any_req       at least one request is present
//                winner        index of the port that would win now
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
   import dmem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       served,
   output logic       any_req,
   output logic       winner
);

   port_idx_t ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= PORT0;
      end else if (update) begin
         ptr <= ~served;
      end
   end

   always_comb begin
      any_req = |req;
      case (req)
         2'b01:   winner = PORT0;
         2'b10:   winner = PORT1;
         default: winner = ptr;   // both (or neither): pointer decides
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Round-robin arbiter in front of the single-ported, byte-
//                addressed 4 KB data memory. Each access runs
//                IDLE -> ACCESS (1 + WAIT_STATES cycles) -> DONE. Stores
//                raise mem_write for exactly one cycle; misaligned requests
//                skip ACCESS and report err with done.
//  Ports       : clk, rst_n               clock / sync active-low reset
//                req/we/addr/wdata{0,1}   requester side, held until done
//                gnt/done/err/rdata{0,1}  per-requester responses
//                mem_adr/mem_wdata/mem_read/mem_write/mem_rdata
//                                         memory side (mem_rdata is
//                                         combinational from mem_adr)
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int WAIT_STATES = 0,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

   state_t              state;
   state_t              state_nxt;
   port_idx_t           owner;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                err_flag;

   logic                any_req;
   port_idx_t           winner;
   logic                ptr_update;

   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                sel_misaligned;
   logic                last_access;

   rr_arbiter2 u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({req1, req0}),
      .update  (ptr_update),
      .served  (owner),
      .any_req (any_req),
      .winner  (winner)
   );

   // Request fields of the current arbitration winner.
   always_comb begin
      sel_we         = (winner == PORT1) ? we1    : we0;
      sel_addr       = (winner == PORT1) ? addr1  : addr0;
      sel_wdata      = (winner == PORT1) ? wdata1 : wdata0;
      sel_misaligned = (sel_addr[1:0] != 2'b00);
   end

   assign last_access = (wait_cnt == '0);

   // State register and latched transaction context.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= PORT0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wait_cnt <= '0;
         err_flag <= 1'b0;
         rdata0   <= '0;
         rdata1   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner    <= winner;
                  we_q     <= sel_we;
                  addr_q   <= sel_addr;
                  wdata_q  <= sel_wdata;
                  wait_cnt <= WAIT_INIT;
                  err_flag <= sel_misaligned;
               end
            end
            ACCESS: begin
               if (last_access) begin
                  if (!we_q) begin
                     if (owner == PORT1) begin
                        rdata1 <= mem_rdata;
                     end else begin
                        rdata0 <= mem_rdata;
                     end
                  end
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next state and Moore outputs. Outputs are held low while rst_n is low
   // so an aborted store cannot write during the reset cycle itself.
   always_comb begin
      state_nxt  = state;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      done0      = 1'b0;
      done1      = 1'b0;
      err0       = 1'b0;
      err1       = 1'b0;
      mem_adr    = '0;
      mem_wdata  = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ptr_update = 1'b0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state_nxt = sel_misaligned ? DONE : ACCESS;
               end
            end
            ACCESS: begin
               gnt0      = (owner == PORT0);
               gnt1      = (owner == PORT1);
               mem_adr   = addr_q;
               mem_wdata = wdata_q;
               mem_read  = ~we_q;
               mem_write = we_q & last_access;
               if (last_access) begin
                  state_nxt = DONE;
               end
            end
            DONE: begin
               gnt0       = (owner == PORT0);
               gnt1       = (owner == PORT1);
               done0      = (owner == PORT0);
               done1      = (owner == PORT1);
               err0       = (owner == PORT0) & err_flag;
               err1       = (owner == PORT1) & err_flag;
               ptr_update = 1'b1;
               state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. A behavioural model
//                (shadow memory, round-robin pointer bit) predicts each
//                completion and pushes it to a queue; a monitor pops and
//                compares on every done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int WS  = 2;
   localparam int LAT = 2 + WS;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, done0, done1, err0, err1;
   logic [31:0] rdata0, rdata1, mem_adr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write;

   always #5 clk = ~clk;

   dmem_arbiter #(.WAIT_STATES(WS), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   // 4 KB memory seen by the DUT.
   logic [31:0] mem [0:1023];
   assign mem_rdata = mem[mem_adr[11:2]];
   always @(posedge clk) if (mem_write) mem[mem_adr[11:2]] <= mem_wdata;

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      bit          port;
      bit          err;
      bit          is_store;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd0;
      logic [31:0] rd1;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] shadow [0:1023];
   logic [31:0] last_rd [0:1];
   bit          ptr_m = 1'b0;
   int          checks = 0, errors = 0;
   int          cyc = 0;
   int          wr_cnt = 0, rd_cnt = 0, exp_wr = 0, exp_rd = 0;
   int          last_wr_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Predict one completion; returns its latency from the IDLE sample cycle.
   task automatic model_push(input bit p, input bit w, input logic [31:0] a,
                             input logic [31:0] d, output int lat);
      exp_t e;
      e.port     = p;
      e.err      = (a[1:0] != 2'b00);
      e.is_store = w && !e.err;
      e.addr     = a;
      e.wdata    = d;
      if (!e.err) begin
         if (w) begin
            shadow[a[11:2]] = d;
            exp_wr++;
         end else begin
            last_rd[p] = shadow[a[11:2]];
            exp_rd += WS + 1;
         end
      end
      e.rd0 = last_rd[0];
      e.rd1 = last_rd[1];
      ptr_m = !p;
      lat   = e.err ? 1 : LAT;
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_outputs",
             {gnt0, gnt1, done0, done1, err0, err1, mem_read, mem_write, mem_adr, mem_wdata}, '0);
      end else begin
         if (mem_write) begin
            wr_cnt++;
            last_wr_cyc = cyc;
         end
         if (mem_read) rd_cnt++;
         if (mem_read && mem_write) chk("rd_wr_exclusive", 2'b11, 2'b00);
         if (done0 || done1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", {done1, done0}, 2'b00);
            end else begin
               mon_e = exp_q.pop_front();
               chk("done_gnt", {gnt1, gnt0, done1, done0}, mon_e.port ? 4'b1010 : 4'b0101);
               chk("err", {err1, err0},
                   mon_e.err ? (mon_e.port ? 2'b10 : 2'b01) : 2'b00);
               chk("rdata", {rdata1, rdata0}, {mon_e.rd1, mon_e.rd0});
            end
         end else if ((gnt0 || gnt1) && exp_q.size() != 0) begin
            mon_e = exp_q[0];
            chk("access_ctl", {gnt1, gnt0, err1, err0, mem_read},
                {mon_e.port, !mon_e.port, 2'b00, !mon_e.is_store});
            chk("access_adr", mem_adr, mon_e.addr);
            if (mon_e.is_store) chk("access_wdata", mem_wdata, mon_e.wdata);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_round(input bit r0, input bit w0i, input logic [31:0] a0, input logic [31:0] d0,
                            input bit r1, input bit w1i, input logic [31:0] a1, input logic [31:0] d1);
      bit first;
      int t_done [0:1];
      int lat, c0, budget;
      bit pend0, pend1;
      first = (r0 && r1) ? ptr_m : !r0;
      if (!first) model_push(1'b0, w0i, a0, d0, lat);
      else        model_push(1'b1, w1i, a1, d1, lat);
      t_done[first] = lat;
      if (r0 && r1) begin
         if (!first) model_push(1'b1, w1i, a1, d1, lat);
         else        model_push(1'b0, w0i, a0, d0, lat);
         t_done[!first] = t_done[first] + 1 + lat;
      end
      @(posedge clk); #1;
      c0 = cyc;
      req0 = r0; we0 = w0i; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1i; addr1 = a1; wdata1 = d1;
      pend0 = r0; pend1 = r1; budget = 0;
      while ((pend0 || pend1) && budget < 60) begin
         @(negedge clk);
         budget++;
         if (pend0 && done0) begin
            chk("latency0", cyc - c0, t_done[0]);
            if (w0i && a0[1:0] == 2'b00) chk("write_cycle0", last_wr_cyc, cyc - 1);
            pend0 = 1'b0;
         end
         if (pend1 && done1) begin
            chk("latency1", cyc - c0, t_done[1]);
            if (w1i && a1[1:0] == 2'b00) chk("write_cycle1", last_wr_cyc, cyc - 1);
            pend1 = 1'b0;
         end
         @(posedge clk); #1;
         if (!pend0) req0 = 1'b0;
         if (!pend1) req1 = 1'b0;
      end
      if (pend0 || pend1) begin
         chk("round_timeout", {pend1, pend0}, 2'b00);
         req0 = 1'b0; req1 = 1'b0;
      end
   endtask

   // Both ports hold a load request for k completions.
   task automatic contention(input int k);
      int lat, c0, seen, budget;
      bit p;
      for (int i = 0; i < k; i++) begin
         p = ptr_m;
         model_push(p, 1'b0, p ? 32'h204 : 32'h100, 32'h0, lat);
      end
      @(posedge clk); #1;
      c0 = cyc;
      we0 = 1'b0; we1 = 1'b0; addr0 = 32'h100; addr1 = 32'h204;
      req0 = 1'b1; req1 = 1'b1;
      seen = 0; budget = 0;
      while (seen < k && budget < 100) begin
         @(negedge clk);
         budget++;
         if (done0 || done1) begin
            chk("contention_time", cyc - c0, LAT + seen * (LAT + 1));
            seen++;
         end
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      if (seen < k) chk("contention_timeout", seen, k);
   endtask

   // Store on port 0 aborted by reset while still counting wait states.
   task automatic reset_abort();
      @(posedge clk); #1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h80; wdata0 = 32'hA5A5_5A5A;
      @(posedge clk); #1;
      rst_n = 1'b0; req0 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      ptr_m = 1'b0; last_rd[0] = '0; last_rd[1] = '0;
      @(negedge clk);
      chk("post_reset_rdata", {rdata1, rdata0}, '0);
   endtask

   // Load whose request lines change once the transaction is latched.
   task automatic input_change();
      int lat, c0, budget;
      bit seen;
      model_push(1'b0, 1'b0, 32'h20, 32'h0, lat);
      @(posedge clk); #1;
      c0 = cyc;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
      @(posedge clk); #1;
      addr0 = 32'h40; req0 = 1'b0; we0 = 1'b1;
      seen = 1'b0; budget = 0;
      while (!seen && budget < 30) begin
         @(negedge clk);
         budget++;
         if (done0) begin
            chk("change_latency", cyc - c0, lat);
            chk("change_value", rdata0, 32'hC0DE_0020);
            seen = 1'b1;
         end
      end
      if (!seen) chk("change_timeout", seen, 1'b1);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) a = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      else                           a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      return a;
   endfunction

   initial begin
      int sel;
      for (int i = 0; i < 1024; i++) begin
         mem[i]    = $urandom;
         shadow[i] = mem[i];
      end
      mem[32'h3E8 >> 2] = 32'hDEAD_BEEF;  shadow[32'h3E8 >> 2] = 32'hDEAD_BEEF;
      mem[32'h20 >> 2]  = 32'hC0DE_0020;  shadow[32'h20 >> 2]  = 32'hC0DE_0020;
      mem[32'h40 >> 2]  = 32'hC0DE_0040;  shadow[32'h40 >> 2]  = 32'hC0DE_0040;
      last_rd[0] = '0; last_rd[1] = '0;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_rdata", {rdata1, rdata0}, '0);

      // continuous contention straight out of reset: 0,1,0,1,...
      contention(6);

      // single aligned load
      run_round(1'b1, 1'b0, 32'h3E8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("load_deadbeef", rdata0, 32'hDEAD_BEEF);

      // store on port 1, then read it back on port 0
      run_round(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
      run_round(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("store_readback", rdata0, 32'h1234_5678);

      // misaligned request: err, no memory access, rdata kept
      run_round(1'b1, 1'b0, 32'h3E9, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("misaligned_keeps_rdata", rdata0, 32'h1234_5678);

      // leave pointer favouring port 1, abort a store, then contend
      run_round(1'b1, 1'b0, 32'h3E8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      reset_abort();
      run_round(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0);

      input_change();

      for (int i = 0; i < 150; i++) begin
         sel = $urandom_range(1, 3);
         run_round(sel[0], 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                   sel[1], 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end

      repeat (3) @(posedge clk);
      chk("write_count", wr_cnt, exp_wr);
      chk("read_cycles", rd_cnt, exp_rd);
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter sharing the single-ported, byte-addressed 4 KB data memory.
- Port 0 is the core load/store path; port 1 is the test/DMA loader.
- Sequences each access as a fixed short transaction with optional wait states and issues exactly one memory write per store.
- Returns read data and a one-cycle done pulse to the winner, and rejects misaligned addresses without touching memory.

Parameters:
- WAIT_STATES, 0, extra ACCESS cycles per transaction (0..15).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- req0 / req1  in  1  access request; held with we/addr/wdata until done
- we0 / we1  in  1  1 = store, 0 = load
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  DATA_W  store data
- gnt0 / gnt1  out  1  port owns memory (ACCESS and DONE states)
- done0 / done1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with done: misaligned address, no access performed
- rdata0 / rdata1  out  DATA_W  load result, held until that port's next successful load
- mem_adr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write data
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, combinational from mem_adr

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset:
  - State goes to IDLE; the priority pointer favours port 0.
  - All gnt, done, err, mem_read and mem_write are 0.
  - mem_adr, mem_wdata, rdata0 and rdata1 are 0.
  - Reset asserted mid-transaction aborts it; no write is issued in the reset cycle.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, select the winner. With only one request, that port wins. With both, the port the pointer favours wins.
  - Latch owner, we, addr, wdata and load wait_cnt = WAIT_STATES.
  - If addr[1:0] != 0, go to DONE with err_flag set. Otherwise go to ACCESS.
  - With no requests, stay in IDLE.
- ACCESS:
  - gnt[owner] = 1.
  - mem_adr = latched addr; mem_wdata = latched wdata; mem_read = !we.
  - mem_write = we && wait_cnt == 0, so exactly one write-enable cycle per store.
  - If wait_cnt == 0: for a load, capture mem_rdata into rdata[owner]; then go to DONE.
  - Otherwise decrement wait_cnt and stay in ACCESS.
- DONE:
  - gnt[owner] = 1; done[owner] = 1; err[owner] = err_flag.
  - Memory enables are 0.
  - The pointer moves to favour the other port; this also applies to erroring transactions.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle N; done at cycle N + 2 + WAIT_STATES.
  - A misaligned request gets done+err at cycle N + 1.
- Back-to-back: IDLE always separates transactions, giving one idle cycle.
  - A requester holding req high after done starts a new transaction, subject to round-robin.
  - Under continuous contention, grants alternate 0,1,0,1.
- Inputs are ignored after latching. Dropping req or changing addr mid-transaction does not affect the transaction in flight.
- The unowned port's done, err and gnt stay 0; its rdata is unchanged.
- Store transactions do not modify rdata.

Decomposition:
- Shared package dmem_pkg: state enum (IDLE, ACCESS, DONE), ADDR_W/DATA_W defaults, and a port-index constant type.
- One natural sub-module: rr_arbiter2, a two-input round-robin grant with a pointer-update strobe. The FSM and datapath muxing stay in the top module.

Test Plan:
- Single load, WAIT_STATES=0:
  - Stimulus: memory holds 0xDEADBEEF at 0x3E8; req0, we0=0, addr0=0x3E8 at cycle 0.
  - Response: mem_read high at cycle 1; done0 at cycle 2; rdata0=0xDEADBEEF; err0=0.
- Store then load, WAIT_STATES=2:
  - Stimulus: port 1 stores 0x12345678 at 0x10.
  - Response: mem_write high exactly one cycle, at cycle 3; done1 at cycle 4.
  - A following load of 0x10 returns 0x12345678.
- Contention:
  - Stimulus: req0 and req1 held high continuously from reset.
  - Response: done order is 0,1,0,1 with a 3-cycle period (WAIT_STATES=0).
- Misaligned address:
  - Stimulus: req0 with addr0=0x3E9.
  - Response: done0=err0=1 at cycle 1; mem_read and mem_write never asserted; rdata0 unchanged.
- Reset mid-transaction:
  - Stimulus: store in ACCESS with WAIT_STATES=3; rst_n low for 1 cycle before wait_cnt reaches 0.
  - Response: no mem_write pulse; all outputs 0; next request is served with port 0 priority.
- Input change mid-transaction:
  - Stimulus: req0 load of 0x20; addr0 changed to 0x40 and req0 dropped during ACCESS.
  - Response: mem_adr stays 0x20; done0 still pulses with the 0x20 data.
